// File: rtl/cluster_event_core_ctrl.sv
// Per-core event controller: sticky event buffer, wake/IRQ masks, register port,
// and the sleep/wake sequencer that gates the core clock on blocking wait reads.
module cluster_event_core_ctrl #(
   parameter int NB_EVENTS = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NB_EVENTS-1:0] events_i,
   input  logic                 core_busy_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [2:0]           addr_i,
   input  logic [31:0]          wdata_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [31:0]          rdata_o,
   output logic                 clk_en_o,
   output logic                 irq_o
);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_SLEEP  = 2'd1,
      ST_WAKE   = 2'd2
   } state_t;

   localparam logic [2:0] A_MASK       = 3'd0;
   localparam logic [2:0] A_BUFFER     = 3'd1;
   localparam logic [2:0] A_BUF_MASKED = 3'd2;
   localparam logic [2:0] A_WAIT       = 3'd3;
   localparam logic [2:0] A_WAIT_CLR   = 3'd4;
   localparam logic [2:0] A_IRQ_MASK   = 3'd5;

   state_t                r_state;
   logic [NB_EVENTS-1:0]  r_buffer;
   logic [NB_EVENTS-1:0]  r_mask;
   logic [NB_EVENTS-1:0]  r_irq_mask;
   logic                  r_clk_en;
   logic                  r_rvalid;
   logic [31:0]           r_rdata;

   logic [NB_EVENTS-1:0]  w_masked;
   logic                  w_pending;
   logic                  w_blocking;
   logic                  w_gnt;
   logic [NB_EVENTS-1:0]  w_clr;
   logic [31:0]           w_rdata_nxt;

   function automatic logic [31:0] zext(input logic [NB_EVENTS-1:0] v);
      logic [31:0] r;
      r = '0;
      r[NB_EVENTS-1:0] = v;
      return r;
   endfunction

   always_comb begin
      w_masked   = r_buffer & r_mask;
      w_pending  = |w_masked;
      w_blocking = !we_i && ((addr_i == A_WAIT) || (addr_i == A_WAIT_CLR));
      // Blocking reads are only accepted once a masked event is already buffered.
      w_gnt      = !rst_i && req_i && (r_state == ST_ACTIVE) && (!w_blocking || w_pending);

      w_clr = '0;
      if (w_gnt && we_i && (addr_i == A_BUFFER))
         w_clr = wdata_i[NB_EVENTS-1:0];
      else if (w_gnt && !we_i && (addr_i == A_WAIT_CLR))
         w_clr = w_masked;

      case (addr_i)
         A_MASK:       w_rdata_nxt = zext(r_mask);
         A_BUFFER:     w_rdata_nxt = zext(r_buffer);
         A_BUF_MASKED,
         A_WAIT,
         A_WAIT_CLR:   w_rdata_nxt = zext(w_masked);
         A_IRQ_MASK:   w_rdata_nxt = zext(r_irq_mask);
         default:      w_rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_ACTIVE;
         r_buffer   <= '0;
         r_mask     <= '0;
         r_irq_mask <= '0;
         r_clk_en   <= 1'b1;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         // Incoming events are OR-ed after the clear so a set wins.
         r_buffer <= (r_buffer & ~w_clr) | events_i;
         r_rvalid <= w_gnt;
         if (w_gnt && !we_i)
            r_rdata <= w_rdata_nxt;
         if (w_gnt && we_i) begin
            if (addr_i == A_MASK)     r_mask     <= wdata_i[NB_EVENTS-1:0];
            if (addr_i == A_IRQ_MASK) r_irq_mask <= wdata_i[NB_EVENTS-1:0];
         end

         case (r_state)
            ST_ACTIVE: begin
               if (req_i && w_blocking && !w_pending && !core_busy_i) begin
                  r_state  <= ST_SLEEP;
                  r_clk_en <= 1'b0;
               end
            end
            ST_SLEEP: begin
               if (w_pending) begin
                  r_state  <= ST_WAKE;
                  r_clk_en <= 1'b1;
               end
            end
            ST_WAKE: begin
               r_state  <= ST_ACTIVE;
               r_clk_en <= 1'b1;
            end
            default: begin
               r_state  <= ST_ACTIVE;
               r_clk_en <= 1'b1;
            end
         endcase
      end
   end

   assign gnt_o    = w_gnt;
   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;
   assign clk_en_o = r_clk_en;
   assign irq_o    = |(r_buffer & r_irq_mask);

endmodule

// File: tb/tb_cluster_event_core_ctrl.sv
// Bench for cluster_event_core_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-level behavioural model of the controller.
module tb_cluster_event_core_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] events_i = '0;
   logic        core_busy_i = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [2:0]  addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        clk_en_o;
   logic        irq_o;

   cluster_event_core_ctrl #(.NB_EVENTS(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .events_i    (events_i),
      .core_busy_i (core_busy_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .clk_en_o    (clk_en_o),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // Model: mode 0 = running, 1 = asleep, 2 = waking.
   logic [31:0] m_buf, m_mask, m_imask, m_rd;
   logic        m_rv, m_gnt;
   int          m_mode, sleep_cnt;
   logic        obs_gnt, obs_clk_en, obs_irq, obs_rvalid;
   logic [31:0] obs_rdata;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_buf = '0; m_mask = '0; m_imask = '0; m_rd = '0;
      m_rv = 1'b0; m_mode = 0; sleep_cnt = 0;
   endtask

   // One clock cycle: drive inputs, compare all outputs, advance the model.
   task automatic cyc(input logic req, input logic we, input logic [2:0] addr,
                      input logic [31:0] wd, input logic [31:0] ev,
                      input logic busy, input logic rst);
      logic        pend, blk;
      logic [31:0] clr;
      @(negedge clk_i);
      req_i = req; we_i = we; addr_i = addr; wdata_i = wd;
      events_i = ev; core_busy_i = busy; rst_i = rst;
      #1;
      pend  = |(m_buf & m_mask);
      blk   = !we && (addr == 3'd3 || addr == 3'd4);
      m_gnt = !rst && req && (m_mode == 0) && (!blk || pend);
      obs_gnt = gnt_o; obs_clk_en = clk_en_o; obs_irq = irq_o;
      obs_rvalid = rvalid_o; obs_rdata = rdata_o;
      check_val("gnt",    {31'd0, gnt_o},    {31'd0, m_gnt});
      check_val("clk_en", {31'd0, clk_en_o}, {31'd0, (m_mode != 1)});
      check_val("irq",    {31'd0, irq_o},    {31'd0, |(m_buf & m_imask)});
      check_val("rvalid", {31'd0, rvalid_o}, {31'd0, m_rv});
      check_val("rdata",  rdata_o,           m_rd);
      if (rst) begin
         model_reset();
      end else begin
         clr = '0;
         if (m_gnt && we && addr == 3'd1) clr = wd;
         if (m_gnt && !we && addr == 3'd4) clr = m_buf & m_mask;
         if (m_gnt && !we) begin
            case (addr)
               3'd0:                m_rd = m_mask;
               3'd1:                m_rd = m_buf;
               3'd2, 3'd3, 3'd4:    m_rd = m_buf & m_mask;
               3'd5:                m_rd = m_imask;
               default:             m_rd = '0;
            endcase
         end
         m_rv = m_gnt;
         if (m_mode == 0)      m_mode = (req && blk && !pend && !busy) ? 1 : 0;
         else if (m_mode == 1) m_mode = pend ? 2 : 1;
         else                  m_mode = 0;
         sleep_cnt = (m_mode == 1) ? sleep_cnt + 1 : 0;
         if (m_gnt && we && addr == 3'd0) m_mask  = wd;
         if (m_gnt && we && addr == 3'd5) m_imask = wd;
         m_buf = (m_buf & ~clr) | ev;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b1, a, d, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      cyc(1'b1, 1'b0, a, 32'd0, 32'd0, 1'b0, 1'b0);
      idle(1);
      check_val(tag, obs_rdata, exp);
   endtask

   initial begin
      logic        h_req, h_we, busy, do_rst;
      logic [2:0]  h_addr;
      logic [31:0] h_wd, ev;
      bit          done;

      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      model_reset();
      cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);

      // Reset state
      rd_chk("rst_mask", 3'd0, 32'd0);
      rd_chk("rst_buf",  3'd1, 32'd0);
      rd_chk("rst_bm",   3'd2, 32'd0);
      rd_chk("rst_imask",3'd5, 32'd0);
      check_val("rst_clk_en", {31'd0, obs_clk_en}, 32'd1);
      check_val("rst_irq",    {31'd0, obs_irq},    32'd0);

      // Sleep on WAIT_CLEAR, wake on event 8 (cycle numbers relative to the MASK write)
      wr(3'd0, 32'h0000_0100);
      idle(1);
      done = 1'b0;
      for (int c = 2; c <= 15; c++) begin
         cyc(!done, 1'b0, 3'd4, 32'd0, (c == 10) ? 32'h100 : 32'h0, 1'b0, 1'b0);
         if (m_gnt) done = 1'b1;
         if (c == 3)  check_val("sleep_clk_en", {31'd0, obs_clk_en}, 32'd0);
         if (c == 11) check_val("still_asleep", {31'd0, obs_clk_en}, 32'd0);
         if (c == 12) check_val("wake_clk_en",  {31'd0, obs_clk_en}, 32'd1);
         if (c == 12) check_val("wake_no_gnt",  {31'd0, obs_gnt},    32'd0);
         if (c == 13) check_val("wake_gnt",     {31'd0, obs_gnt},    32'd1);
         if (c == 14) check_val("wake_rvalid",  {31'd0, obs_rvalid}, 32'd1);
         if (c == 14) check_val("wake_rdata",   obs_rdata,           32'h100);
      end
      rd_chk("wclr_buf", 3'd1, 32'd0);

      // Set wins over simultaneous write-1-to-clear
      cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'h3, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 32'h1, 32'h1, 1'b0, 1'b0);
      rd_chk("set_wins", 3'd1, 32'h3);
      wr(3'd1, 32'hFFFF_FFFF);

      // IRQ raise and clear
      wr(3'd5, 32'h8000_0000);
      cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
      idle(1);
      check_val("irq_set", {31'd0, obs_irq}, 32'd1);
      wr(3'd1, 32'h8000_0000);
      idle(1);
      check_val("irq_clr", {31'd0, obs_irq}, 32'd0);
      wr(3'd5, 32'h0);

      // Blocking WAIT while busy: no sleep, grant one cycle after event
      done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(!done, 1'b0, 3'd3, 32'd0, (k == 2) ? 32'h100 : 32'h0, 1'b1, 1'b0);
         if (m_gnt) done = 1'b1;
         check_val("busy_clk_en", {31'd0, obs_clk_en}, 32'd1);
         if (k == 2) check_val("busy_no_gnt", {31'd0, obs_gnt}, 32'd0);
         if (k == 3) check_val("busy_gnt",    {31'd0, obs_gnt}, 32'd1);
         if (k == 4) check_val("busy_rdata",  obs_rdata, 32'h100);
      end
      rd_chk("wait_no_clr", 3'd1, 32'h100);
      wr(3'd1, 32'hFFFF_FFFF);

      // Reset while asleep
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 3'd3, 32'd0, 32'd0, 1'b0, 1'b0);
      check_val("sleep_before_rst", {31'd0, obs_clk_en}, 32'd0);
      cyc(1'b1, 1'b0, 3'd3, 32'd0, 32'd0, 1'b0, 1'b1);
      idle(1);
      check_val("rst_sleep_clk_en", {31'd0, obs_clk_en}, 32'd1);
      rd_chk("rst_sleep_mask", 3'd0, 32'd0);
      rd_chk("rst_sleep_buf",  3'd1, 32'd0);

      // Randomized traffic; requests are held until granted
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!h_req && $urandom_range(0, 2) != 0) begin
            h_req  = 1'b1;
            h_we   = 1'($urandom_range(0, 1));
            h_addr = 3'($urandom_range(0, 7));
            h_wd   = $urandom();
         end
         ev     = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
         busy   = ($urandom_range(0, 3) == 0);
         do_rst = (m_mode == 1 && sleep_cnt > 30);
         if (do_rst) h_req = 1'b0;
         cyc(h_req, h_we, h_addr, h_wd, ev, busy, do_rst);
         if (m_gnt) h_req = 1'b0;
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
